fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch (I-stage) front end of the three-stage Riscv151 pipeline, directly upstream of the controller and datapath decode. It owns the architectural fetch PC and drives the synchronous-read instruction cache. It presents one instruction per cycle, with its PC, to the I stage. It applies redirects (jumps and taken branches), stalls and kills that the controller produces, inserting NOPs where the fetched word is invalid or wrong-path.

## Interface
- RESET_PC, 32'h4000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, word substituted for invalid or killed instructions (addi x0,x0,0)

- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_sel  input  2  0 = sequential (PC+4), 1 = redirect to alu_target, 2/3 = treated as 0
- alu_target  input  32  redirect target from the X-stage ALU
- inst_kill  input  1  replace the current I-stage instruction with NOP_INST this cycle
- stall  input  1  hold the I-stage instruction and PC
- icache_dout  input  32  instruction word for the address presented last cycle
- icache_addr  output  32  fetch address; data returns next cycle
- icache_re  output  1  cache read enable
- inst  output  32  I-stage instruction to decode
- inst_pc  output  32  PC of inst
- inst_valid  output  1  inst is a real, non-killed instruction
- fetch_misaligned  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State:
  - pc_F (32): address whose data is on icache_dout.
  - valid_F (1): icache_dout is meaningful.
  - rd_pend (1) and rd_pc (32): redirect deferred by a stall.
- Reset values: pc_F = RESET_PC, valid_F = 0, rd_pend = 0, rd_pc = 0, fetch_misaligned = 0.
- Redirect: redir = (pc_sel == 1).
- Target: tgt = {alu_target[31:2], 2'b00}; bits [1:0] are always forced to zero.
- icache_addr priority, highest first:
  - reset: RESET_PC.
  - redir && !stall: tgt.
  - rd_pend && !stall: rd_pc.
  - stall || !valid_F: pc_F.
  - otherwise: pc_F + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Each edge: pc_F ← icache_addr; valid_F ← !reset.
- Redirect during stall: rd_pend ← 1, rd_pc ← tgt. A later redirect during the same stall overwrites rd_pc.
- rd_pend clears on the first non-stall cycle.
- A live redirect on the release cycle wins over rd_pc.
- icache_re = !reset.
- inst_pc = pc_F.
- Kill condition: kill_I = !valid_F || inst_kill || (rd_pend && !stall).
  - kill_I = 1: inst = NOP_INST, inst_valid = 0.
  - kill_I = 0: inst = icache_dout, inst_valid = 1.
- During reset: inst = NOP_INST, inst_valid = 0.

## Timing
- Cycle 0 after reset deasserts:
  - valid_F = 0, inst = NOP, icache_addr = RESET_PC.
- Cycle 1: inst = word@RESET_PC, inst_valid = 1.
- Sequential fetch delivers one instruction per cycle.
- Redirect latency: redir asserted in cycle t puts word@tgt on inst in cycle t+1. Killing the wrong-path word in cycle t is the controller's job via inst_kill.
- Stall:
  - icache_addr re-presents pc_F, so inst and inst_pc stay constant for every stalled cycle and the cycle after.
  - No instruction is lost or duplicated.
- Stall release with rd_pend set:
  - That cycle: inst is NOP (wrong path) and icache_addr = rd_pc.
  - Next cycle: inst = word@rd_pc.
- inst_kill is combinational to inst and inst_valid. It has no effect on PC state.
- Reset mid-stall or with rd_pend set: all state returns to reset values on that edge.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with alu_target[1:0] != 0 sets fetch_misaligned on the next edge.
  - The flag stays 1 until reset.
  - The checked target is the live redirect, including one deferred by a stall.
  - Fetch proceeds from the zero-aligned target.
- Not defined: fetch_misaligned is tied to 0 and no check logic is built; alignment forcing is unchanged.

## Test plan
- Reset for 2 cycles, then run:
  - Cycle 0: inst = 0x00000013, valid 0.
  - Cycles 1..3: inst_pc = 0x40000000/04/08, valid 1.
- pc_sel = 1, alu_target = 0x40000100 in cycle 5 -> cycle 6 inst_pc = 0x40000100; cycle 7 inst_pc = 0x40000104.
- stall for 3 cycles at inst_pc = 0x40000008 -> inst and inst_pc constant for all 3 cycles; the cycle after release shows 0x4000000C.
- Redirect to 0x40000200 during stall, then release:
  - Release cycle: inst = NOP, valid 0.
  - Next cycle: inst_pc = 0x40000200.
  - A second redirect to 0x40000300 in the release cycle -> 0x40000300 instead.
- inst_kill pulse for one cycle -> inst = 0x00000013, valid 0 that cycle only; PC sequence unaffected.
- Wrap and alignment:
  - Sequential from 0xFFFFFFFC -> 0x00000000.
  - Redirect to 0x40000102 -> fetch 0x40000100.
  - fetch_misaligned = 1 only with FETCH_MISALIGN_CHECK_EN; remains 1 until reset.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the three-stage Riscv151 pipeline.
// Owns the fetch PC, drives the synchronous-read instruction cache, and hands
// one instruction per cycle (with its PC) to the I stage. Redirects, stalls and
// kills from the controller are applied here; wrong-path or invalid words are
// replaced with NOP_INST.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   -> sticky fetch_misaligned flag set by any redirect whose target
//                has non-zero bits [1:0]
//   undefined -> fetch_misaligned is tied to 0
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_target,
  input  logic        inst_kill,
  input  logic        stall,
  input  logic [31:0] icache_dout,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_misaligned
);

  // pc_f is the address whose data is currently on icache_dout.
  logic [31:0] pc_f;
  logic        valid_f;
  // Redirect that arrived while the pipeline was stalled, applied on release.
  logic        rd_pend;
  logic [31:0] rd_pc;

  logic        redir;
  logic [31:0] tgt;
  logic        kill_i;

  assign redir = (pc_sel == 2'd1);
  // Targets are always word aligned; the low bits are dropped, never trapped.
  assign tgt   = {alu_target[31:2], 2'b00};

  // Next fetch address, in strict priority order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    icache_addr = pc_f + 32'd4;
    if (reset) begin
      icache_addr = RESET_PC;
    end else if (redir && !stall) begin
      icache_addr = tgt;
    end else if (rd_pend && !stall) begin
      icache_addr = rd_pc;
    end else if (stall || !valid_f) begin
      // Re-present the same address so the cache returns the same word again.
      icache_addr = pc_f;
    end
  end

  assign icache_re = !reset;

  // Fetch PC and data-valid tracking; pc_f follows whatever was presented.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_f    <= RESET_PC;
      valid_f <= 1'b0;
    end else begin
      pc_f    <= icache_addr;
      valid_f <= 1'b1;
    end
  end

  // Deferred-redirect capture: the latest redirect seen during a stall wins,
  // and the entry is consumed on the first non-stalled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_pc   <= '0;
    end else if (stall) begin
      if (redir) begin
        rd_pend <= 1'b1;
        rd_pc   <= tgt;
      end
    end else begin
      rd_pend <= 1'b0;
    end
  end

  // On stall release with a deferred redirect, the word on icache_dout is
  // from the old path, so it is squashed along with invalid or killed words.
  assign kill_i     = reset || !valid_f || inst_kill || (rd_pend && !stall);
  assign inst       = kill_i ? NOP_INST : icache_dout;
  assign inst_valid = !kill_i;
  assign inst_pc    = pc_f;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misaligned-target flag; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else if (redir && (alu_target[1:0] != 2'b00)) begin
      fetch_misaligned <= 1'b1;
    end
  end
`else
  // Without the check the low target bits are simply discarded.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs  = ^alu_target[1:0];
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A stimulus process drives
// each cycle, asks a reference model what the fetch unit must show that cycle,
// and queues it; a monitor on the falling edge pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_sel;
  logic [31:0] alu_target;
  logic        inst_kill;
  logic        stall;
  logic [31:0] icache_dout;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .pc_sel           (pc_sel),
    .alu_target       (alu_target),
    .inst_kill        (inst_kill),
    .stall            (stall),
    .icache_dout      (icache_dout),
    .icache_addr      (icache_addr),
    .icache_re        (icache_re),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_valid       (inst_valid),
    .fetch_misaligned (fetch_misaligned)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  // Synchronous-read cache: data for last cycle's address.
  always @(posedge clk) begin
    if (icache_re) icache_dout <= mem_word(icache_addr);
  end

  typedef struct {
    logic        full;     // PC / flag state is defined (not before first edge)
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic        re;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("icache_addr", icache_addr, e.addr);
      check("icache_re", {31'b0, icache_re}, {31'b0, e.re});
      check("inst", inst, e.inst);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, e.valid});
      if (e.full) begin
        check("inst_pc", inst_pc, e.pc);
        check("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, e.mis});
      end
    end
  end

  // Reference model: the architectural view of the fetch stream.
  //   cur_pc     : PC the I stage is holding this cycle
  //   have_word  : the cache has returned a word for cur_pc
  //   deferred   : queued redirect target waiting for a stall to end
  //   sticky_mis : misaligned-redirect history since reset
  logic        started    = 1'b0;
  logic [31:0] cur_pc;
  logic        have_word;
  logic        deferred_ok;
  logic [31:0] deferred;
  logic        sticky_mis;

  task automatic cycle(input logic r, input logic [1:0] sel, input logic [31:0] tgt_in,
                       input logic st, input logic k);
    exp_t        e;
    logic        jump;
    logic [31:0] aligned;
    logic [31:0] next_pc;
    logic        wrong_path;

    reset = r; pc_sel = sel; alu_target = tgt_in; stall = st; inst_kill = k;

    jump    = (sel == 2'd1);
    aligned = tgt_in & 32'hFFFF_FFFC;

    // Where the fetch stream goes next.
    if (r)                        next_pc = RESET_PC;
    else if (jump && !st)         next_pc = aligned;
    else if (deferred_ok && !st)  next_pc = deferred;
    else if (st || !have_word)    next_pc = cur_pc;
    else                          next_pc = cur_pc + 32'd4;

    wrong_path = deferred_ok && !st;
    e.full  = started;
    e.addr  = next_pc;
    e.re    = !r;
    e.pc    = cur_pc;
    e.mis   = sticky_mis;
    e.valid = !r && have_word && !k && !wrong_path;
    e.inst  = e.valid ? mem_word(cur_pc) : NOP_INST;
    sb.push_back(e);

    // Advance the stream past this clock edge.
    cur_pc    = next_pc;
    have_word = !r;
    if (r) begin
      deferred_ok = 1'b0;
      sticky_mis  = 1'b0;
    end else begin
      if (st && jump) begin
        deferred_ok = 1'b1;
        deferred    = aligned;
      end else if (!st) begin
        deferred_ok = 1'b0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (jump && tgt_in[1:0] != 2'b00) sticky_mis = 1'b1;
`endif
    end
    started = 1'b1;

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; pc_sel = 2'd0; alu_target = '0; stall = 1'b0; inst_kill = 1'b0;
    @(posedge clk);
    #1;

    // Reset, start-up and sequential fetch; redirect in cycle 5.
    do_reset(2);
    run(5);
    cycle(1'b0, 2'd1, 32'h4000_0100, 1'b0, 1'b0);
    run(3);

    // Stall three cycles while holding 0x40000008.
    do_reset(2);
    run(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    run(3);

    // Redirect deferred by a stall, then released.
    cycle(1'b0, 2'd1, 32'h4000_0200, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    run(3);

    // Deferred redirect overridden by a live redirect on the release cycle.
    cycle(1'b0, 2'd1, 32'h4000_0200, 1'b1, 1'b0);
    cycle(1'b0, 2'd1, 32'h4000_0280, 1'b1, 1'b0);
    cycle(1'b0, 2'd1, 32'h4000_0300, 1'b0, 1'b0);
    run(3);

    // Single-cycle kill pulse.
    cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    run(2);

    // pc_sel encodings 2 and 3 behave as sequential.
    cycle(1'b0, 2'd2, 32'h1234_5678, 1'b0, 1'b0);
    cycle(1'b0, 2'd3, 32'h1234_5678, 1'b0, 1'b0);
    run(1);

    // Misaligned redirect, then sticky flag across normal fetch.
    cycle(1'b0, 2'd1, 32'h4000_0102, 1'b0, 1'b0);
    run(4);

    // Wrap from the top of the address space.
    cycle(1'b0, 2'd1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    run(4);

    // Reset while stalled with a deferred redirect pending.
    cycle(1'b0, 2'd1, 32'h4000_0401, 1'b1, 1'b0);
    cycle(1'b1, 2'd0, 32'h0, 1'b1, 1'b0);
    run(4);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic [1:0]  sel;
      logic [31:0] t;
      r   = ($urandom_range(99) < 2);
      sel = ($urandom_range(9) < 2) ? 2'd1 : 2'($urandom_range(3) == 0 ? 2 : 0);
      t   = $urandom();
      if ($urandom_range(3) != 0) t = {16'h4000, t[15:0]};
      cycle(r, sel, t, ($urandom_range(3) == 0), ($urandom_range(9) == 0));
    end
    run(2);

    // The monitor must have consumed every expectation.
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
